// File: rtl/risk_tile_mem_if.sv
// Request/response bundle for the strided tile memory.
interface risk_tile_mem_if #(
  parameter int SZ       = 4,
  parameter int WORD     = 18,
  parameter int ADDR_W   = 17,
  parameter int STRIDE_W = 15
);
  logic                    req_valid;
  logic                    req_ready;
  logic                    req_we;
  logic [ADDR_W-1:0]       req_addr;
  logic [STRIDE_W-1:0]     req_stride_x;
  logic [STRIDE_W-1:0]     req_stride_y;
  logic [SZ*SZ*WORD-1:0]   req_wdata;
  logic                    rsp_valid;
  logic                    rsp_ready;
  logic [SZ*SZ*WORD-1:0]   rsp_rdata;

  modport master (
    output req_valid, req_we, req_addr, req_stride_x, req_stride_y, req_wdata, rsp_ready,
    input  req_ready, rsp_valid, rsp_rdata
  );

  modport slave (
    input  req_valid, req_we, req_addr, req_stride_x, req_stride_y, req_wdata, rsp_ready,
    output req_ready, rsp_valid, rsp_rdata
  );
endinterface

// File: rtl/risk_tile_mem.sv
// Strided SZ x SZ tile gather/scatter across BANKS single-port banks, conflicts resolved in rounds.
// Define RISK_CONFLICT_CNT_EN to add the stat_conflict extra-round counter port.
module risk_tile_mem #(
  parameter int SZ         = 4,
  parameter int WORD       = 18,
  parameter int BANKS      = 128,
  parameter int BANK_DEPTH = 1024,
  parameter int ADDR_W     = 17,
  parameter int STRIDE_W   = 15
) (
  input  logic            clk,
  input  logic            reset,
  risk_tile_mem_if.slave  bus
`ifdef RISK_CONFLICT_CNT_EN
  ,
  output logic [31:0]     stat_conflict
`endif
);
  // state | meaning
  // IDLE  | accepting a request
  // ADDR  | element addresses split into bank/row, all elements pending
  // ISSUE | one bank access per bank per cycle until nothing pending
  // DRAIN | last round's read data lands
  // RESP  | response held until consumed
  localparam int NE = SZ * SZ;
  localparam int BB = $clog2(BANKS);
  localparam int RW = ADDR_W - BB;

  typedef enum logic [2:0] {S_IDLE, S_ADDR, S_ISSUE, S_DRAIN, S_RESP} state_t;

  state_t              r_state;
  logic                r_req_ready;
  logic                r_rsp_valid;
  logic [NE*WORD-1:0]  r_rsp_rdata;
  logic                r_we;
  logic [NE*WORD-1:0]  r_wdata;
  logic [ADDR_W-1:0]   r_base;
  logic [STRIDE_W-1:0] r_sx;
  logic [STRIDE_W-1:0] r_sy;
  logic [BB-1:0]       r_bank [NE];
  logic [RW-1:0]       r_row  [NE];
  logic [NE-1:0]       r_pend;
  logic [NE-1:0]       r_rd_slot;
`ifdef RISK_CONFLICT_CNT_EN
  logic [31:0]         r_stat_conflict;
  logic                r_first;
`endif

  logic [ADDR_W-1:0]   w_addr [NE];
  logic [NE-1:0]       w_served;
  logic [NE-1:0]       w_clear;
  logic [BANKS-1:0]    w_bank_en;
  logic [RW-1:0]       w_bank_row [BANKS];
  logic [WORD-1:0]     w_bank_wd  [BANKS];
  logic [WORD-1:0]     w_q        [BANKS];

  always_comb begin
    for (int e = 0; e < NE; e++)
      w_addr[e] = r_base + ADDR_W'(r_sx) * ADDR_W'(e % SZ) + ADDR_W'(r_sy) * ADDR_W'(e / SZ);
  end

  // Each bank serves its lowest pending element; reads also retire same-row duplicates.
  always_comb begin
    w_served = r_pend;
    for (int e = 0; e < NE; e++)
      for (int j = 0; j < e; j++)
        if (r_pend[j] && r_bank[j] == r_bank[e]) w_served[e] = 1'b0;
    w_clear = w_served;
    if (!r_we)
      for (int e = 0; e < NE; e++)
        for (int j = 0; j < NE; j++)
          if (w_served[j] && r_bank[j] == r_bank[e] && r_row[j] == r_row[e])
            w_clear[e] = r_pend[e];
  end

  always_comb begin
    w_bank_en = '0;
    for (int b = 0; b < BANKS; b++) begin
      w_bank_row[b] = '0;
      w_bank_wd[b]  = '0;
    end
    if (r_state == S_ISSUE)
      for (int e = 0; e < NE; e++)
        if (w_served[e]) begin
          w_bank_en[r_bank[e]]  = 1'b1;
          w_bank_row[r_bank[e]] = r_row[e];
          w_bank_wd[r_bank[e]]  = r_wdata[e*WORD +: WORD];
        end
  end

  for (genvar b = 0; b < BANKS; b++) begin : g_bank
    logic [WORD-1:0] r_mem [BANK_DEPTH];
    logic [WORD-1:0] r_q;
    always_ff @(posedge clk) begin
      if (w_bank_en[b]) begin
        if (r_we) r_mem[w_bank_row[b]] <= w_bank_wd[b];
        else      r_q <= r_mem[w_bank_row[b]];
      end
    end
    assign w_q[b] = r_q;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state     <= S_IDLE;
      r_req_ready <= 1'b1;
      r_rsp_valid <= 1'b0;
      r_rsp_rdata <= '0;
      r_we        <= 1'b0;
      r_wdata     <= '0;
      r_base      <= '0;
      r_sx        <= '0;
      r_sy        <= '0;
      r_pend      <= '0;
      r_rd_slot   <= '0;
      for (int e = 0; e < NE; e++) begin
        r_bank[e] <= '0;
        r_row[e]  <= '0;
      end
`ifdef RISK_CONFLICT_CNT_EN
      r_stat_conflict <= '0;
      r_first         <= 1'b0;
`endif
    end else begin
      r_rd_slot <= '0;
      for (int e = 0; e < NE; e++)
        if (r_rd_slot[e]) r_rsp_rdata[e*WORD +: WORD] <= w_q[r_bank[e]];
      case (r_state)
        S_IDLE: begin
          if (bus.req_valid && r_req_ready) begin
            r_we        <= bus.req_we;
            r_wdata     <= bus.req_wdata;
            r_base      <= bus.req_addr;
            r_sx        <= bus.req_stride_x;
            r_sy        <= bus.req_stride_y;
            r_req_ready <= 1'b0;
            r_state     <= S_ADDR;
          end
        end
        S_ADDR: begin
          for (int e = 0; e < NE; e++) begin
            r_bank[e] <= w_addr[e][BB-1:0];
            r_row[e]  <= w_addr[e][ADDR_W-1:BB];
          end
          r_pend  <= '1;
          r_state <= S_ISSUE;
`ifdef RISK_CONFLICT_CNT_EN
          r_first <= 1'b1;
`endif
        end
        S_ISSUE: begin
          r_pend <= r_pend & ~w_clear;
          if (!r_we) r_rd_slot <= w_clear;
          if ((r_pend & ~w_clear) == '0) r_state <= S_DRAIN;
`ifdef RISK_CONFLICT_CNT_EN
          if (!r_first && r_stat_conflict != '1) r_stat_conflict <= r_stat_conflict + 32'd1;
          r_first <= 1'b0;
`endif
        end
        S_DRAIN: begin
          r_rsp_valid <= 1'b1;
          r_state     <= S_RESP;
        end
        S_RESP: begin
          if (bus.rsp_ready) begin
            r_rsp_valid <= 1'b0;
            r_req_ready <= 1'b1;
            r_state     <= S_IDLE;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign bus.req_ready = r_req_ready;
  assign bus.rsp_valid = r_rsp_valid;
  assign bus.rsp_rdata = r_rsp_rdata;
`ifdef RISK_CONFLICT_CNT_EN
  assign stat_conflict = r_stat_conflict;
`endif
endmodule

// File: tb/tb_risk_tile_mem.sv
// Scoreboard bench for risk_tile_mem: an address-level memory model predicts data and round counts.
module tb_risk_tile_mem;
  localparam int SZ = 4, WORD = 18, BANKS = 128, BANK_DEPTH = 1024, ADDR_W = 17, STRIDE_W = 15;
  localparam int NE = SZ * SZ;
  localparam int DW = NE * WORD;

  typedef struct {
    logic          we;
    logic [DW-1:0] data;
    logic [NE-1:0] mask;
    int            lat;
    longint        acc;
  } exp_t;

  logic clk, reset;
  longint cyc = 0;
  int vectors = 0, miscompares = 0;
  int hold_n = 0;
  bit rand_ready = 0;
  bit prev_v = 0;
  longint last_hs = -100;

  exp_t sb_q[$];
  logic [WORD-1:0] m_mem [int];
  logic [DW-1:0] m_rdata;
  logic [NE-1:0] m_rmask;
  longint m_stat = 0;

  risk_tile_mem_if #(.SZ(SZ), .WORD(WORD), .ADDR_W(ADDR_W), .STRIDE_W(STRIDE_W)) bus();
`ifdef RISK_CONFLICT_CNT_EN
  logic [31:0] stat_conflict;
`endif

  risk_tile_mem #(.SZ(SZ), .WORD(WORD), .BANKS(BANKS), .BANK_DEPTH(BANK_DEPTH),
                  .ADDR_W(ADDR_W), .STRIDE_W(STRIDE_W)) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
`ifdef RISK_CONFLICT_CNT_EN
    , .stat_conflict(stat_conflict)
`endif
  );

  initial begin
    clk = 0;
    forever #5 clk = ~clk;
  end

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  task automatic chk(input string nm, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h required %h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  task automatic fail_now(input string nm);
    vectors++;
    miscompares++;
    $display("FAIL %s (cycle %0d)", nm, cyc);
  endtask

  function automatic logic [DW-1:0] bmask(input logic [NE-1:0] m);
    logic [DW-1:0] r = '0;
    for (int e = 0; e < NE; e++) if (m[e]) r[e*WORD +: WORD] = '1;
    return r;
  endfunction

  // Rounds = worst bank's element count (stores) or distinct-address count (loads).
  task automatic model_push(input logic we, input int base, input int sx, input int sy,
                            input logic [DW-1:0] wd, input longint acc);
    int addr[NE];
    int per_bank[int];
    bit seen[int];
    int k = 0;
    exp_t x;
    for (int e = 0; e < NE; e++) addr[e] = (base + sx * (e % SZ) + sy * (e / SZ)) % (1 << ADDR_W);
    for (int e = 0; e < NE; e++) begin
      if (we || !seen.exists(addr[e])) begin
        int b = addr[e] % BANKS;
        seen[addr[e]] = 1;
        per_bank[b] = per_bank.exists(b) ? per_bank[b] + 1 : 1;
        if (per_bank[b] > k) k = per_bank[b];
      end
    end
    if (we) begin
      for (int e = 0; e < NE; e++) m_mem[addr[e]] = wd[e*WORD +: WORD];
    end else begin
      m_rmask = '0;
      for (int e = 0; e < NE; e++)
        if (m_mem.exists(addr[e])) begin
          m_rdata[e*WORD +: WORD] = m_mem[addr[e]];
          m_rmask[e] = 1'b1;
        end
    end
    x.we = we; x.data = m_rdata; x.mask = m_rmask; x.lat = 3 + k; x.acc = acc;
    sb_q.push_back(x);
    m_stat += k - 1;
  endtask

  task automatic send(input logic we, input int base, input int sx, input int sy,
                      input logic [DW-1:0] wd, output longint acc);
    int n = 0;
    bit done = 0;
    acc = -1;
    @(posedge clk); #1;
    bus.req_we       = we;
    bus.req_addr     = ADDR_W'(base);
    bus.req_stride_x = STRIDE_W'(sx);
    bus.req_stride_y = STRIDE_W'(sy);
    bus.req_wdata    = wd;
    bus.req_valid    = 1'b1;
    while (!done) begin
      @(negedge clk);
      if (bus.req_ready) begin
        acc = cyc;
        model_push(we, base, sx, sy, wd, acc);
        done = 1;
      end else if (++n > 400) begin
        fail_now("accept_timeout");
        done = 1;
      end
    end
    @(posedge clk); #1;
    bus.req_valid = 1'b0;
  endtask

  initial begin
    bus.rsp_ready = 1'b1;
    forever begin
      @(posedge clk); #1;
      if (bus.rsp_valid && hold_n > 0) begin
        bus.rsp_ready = 1'b0;
        hold_n--;
      end else if (rand_ready) bus.rsp_ready = ($urandom_range(0, 3) != 0);
      else bus.rsp_ready = 1'b1;
    end
  end

  // Monitor: every cycle a response is shown it must match the head of the scoreboard.
  initial forever begin
    @(negedge clk);
    if (reset) prev_v = 0;
    else begin
      if (bus.rsp_valid) begin
        chk("req_ready_low_in_resp", DW'(bus.req_ready), DW'(0));
        if (sb_q.size() == 0) begin
          if (!prev_v) fail_now("unexpected_rsp");
        end else begin
          logic [DW-1:0] m;
          if (!prev_v) chk("latency", DW'(cyc - sb_q[0].acc), DW'(sb_q[0].lat));
          m = bmask(sb_q[0].mask);
          if (sb_q[0].we) chk("store_rdata_kept", bus.rsp_rdata & m, sb_q[0].data & m);
          else            chk("load_rdata", bus.rsp_rdata & m, sb_q[0].data & m);
          if (bus.rsp_ready) begin
            last_hs = cyc;
            void'(sb_q.pop_front());
          end
        end
      end
      prev_v = bus.rsp_valid;
    end
  end

  task automatic wait_idle();
    int n = 0;
    while (sb_q.size() != 0 && n < 3000) begin
      @(negedge clk);
      n++;
    end
    if (sb_q.size() != 0) fail_now("response_timeout");
  endtask

  initial begin
    logic [DW-1:0] wd;
    longint acc_a, acc_b;
    int opts[10] = '{0, 1, 2, 4, 16, 17, 128, 129, 256, 3};

    reset = 1'b1;
    bus.req_valid = 0; bus.req_we = 0; bus.req_addr = '0;
    bus.req_stride_x = '0; bus.req_stride_y = '0; bus.req_wdata = '0;
    m_rdata = '0; m_rmask = '1;
    repeat (3) @(negedge clk);
    chk("reset_req_ready", DW'(bus.req_ready), DW'(1));
    chk("reset_rsp_valid", DW'(bus.rsp_valid), DW'(0));
    chk("reset_rsp_rdata", bus.rsp_rdata, '0);
`ifdef RISK_CONFLICT_CNT_EN
    chk("reset_stat", DW'(stat_conflict), DW'(0));
`endif
    @(posedge clk); #1 reset = 1'b0;

    for (int e = 0; e < NE; e++) wd[e*WORD +: WORD] = WORD'(e + 1);
    send(1, 0, 1, 4, wd, acc_a); wait_idle();
    send(0, 0, 1, 4, '0, acc_a); wait_idle();

    for (int e = 0; e < NE; e++) wd[e*WORD +: WORD] = WORD'('h100 + e % SZ);
    send(1, 0, 128, 512, wd, acc_a); wait_idle();
    send(0, 0, 128, 0, '0, acc_a); wait_idle();

    for (int e = 0; e < NE; e++) wd[e*WORD +: WORD] = WORD'(e);
    send(1, 5, 0, 0, wd, acc_a); wait_idle();
    send(0, 5, 0, 0, '0, acc_a); wait_idle();

    for (int e = 0; e < NE; e++) wd[e*WORD +: WORD] = WORD'($urandom);
    send(1, (1 << ADDR_W) - 2, 1, 0, wd, acc_a); wait_idle();
    send(0, (1 << ADDR_W) - 2, 1, 0, '0, acc_a); wait_idle();
    send(0, 0, 1, 0, '0, acc_a); wait_idle();

    hold_n = 5;
    send(0, 0, 1, 4, '0, acc_a);
    send(0, 0, 128, 0, '0, acc_b);
    chk("back_to_back_accept", DW'(acc_b), DW'(last_hs + 1));
    wait_idle();

    send(0, 0, 128, 0, '0, acc_a);
    @(posedge clk); #1;
    reset = 1'b1;
    sb_q.delete();
    m_stat = 0; m_rdata = '0; m_rmask = '1;
    repeat (3) begin
      @(negedge clk);
      chk("midop_reset_rsp_valid", DW'(bus.rsp_valid), DW'(0));
      chk("midop_reset_req_ready", DW'(bus.req_ready), DW'(1));
    end
    @(posedge clk); #1 reset = 1'b0;
    send(0, 0, 128, 0, '0, acc_a); wait_idle();

    rand_ready = 1;
    for (int i = 0; i < 150; i++) begin
      int base, sx, sy;
      base = ($urandom_range(0, 7) == 0) ? int'($urandom_range(0, (1 << ADDR_W) - 1))
                                        : int'($urandom_range(0, 1023));
      sx = ($urandom_range(0, 9) == 0) ? int'($urandom_range(0, (1 << STRIDE_W) - 1))
                                      : opts[$urandom_range(0, 9)];
      sy = ($urandom_range(0, 9) == 0) ? int'($urandom_range(0, (1 << STRIDE_W) - 1))
                                      : opts[$urandom_range(0, 9)];
      for (int e = 0; e < NE; e++) wd[e*WORD +: WORD] = WORD'($urandom);
      send(logic'($urandom_range(0, 1)), base, sx, sy, wd, acc_a);
    end
    wait_idle();
    rand_ready = 0;
    repeat (3) @(negedge clk);
    chk("scoreboard_empty", DW'(sb_q.size()), DW'(0));
`ifdef RISK_CONFLICT_CNT_EN
    chk("stat_conflict", DW'(stat_conflict), DW'(m_stat));
`endif
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
